// File: rtl/phase_accumulator.sv
// Per-voice oscillator core: byte-written frequency word, prescaled tick, 24-bit phase accumulator.
// Define HARD_SYNC_EN to let sync_in (gated by control bit1) reset the phase on the next tick.
module phase_accumulator #(
    parameter int unsigned ACCUMULATOR_BITS = 24,
    parameter int unsigned FREQ_BITS        = 16,
    parameter int unsigned PRESCALE_DIV     = 50
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [1:0]                  wr_addr,
    input  logic [7:0]                  wr_data,
    input  logic                        sync_in,
    output logic [ACCUMULATOR_BITS-1:0] accumulator,
    output logic                        acc_msb,
    output logic                        msb_rise,
    output logic                        tick
);
    localparam int unsigned CNT_W   = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam int unsigned HI_BITS = FREQ_BITS - 8;
    localparam int unsigned MSB     = ACCUMULATOR_BITS - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE_DIV - 1);

    logic [CNT_W-1:0]            count_q, count_d;
    logic                        tick_q, tick_d;
    logic [ACCUMULATOR_BITS-1:0] acc_q, acc_d, sum;
    logic                        rise_q, rise_d;
    logic [FREQ_BITS-1:0]        freq_q, freq_d;
    logic [7:0]                  lo_q, lo_d;
    logic [1:0]                  ctrl_q, ctrl_d;
    logic                        tick_now;
    logic                        sync_hit;

    // The accumulator updates on the same edge that raises tick, so writes
    // landing on that edge naturally only affect the following tick.
    always_comb begin
        tick_now = (count_q == CNT_LAST);
        count_d  = tick_now ? '0 : count_q + 1'b1;
        tick_d   = tick_now;
        sum      = acc_q + ACCUMULATOR_BITS'(freq_q);
        acc_d    = acc_q;
        rise_d   = 1'b0;
        if (tick_now) begin
            if (ctrl_q[0] || sync_hit) begin
                acc_d = '0;
            end else begin
                acc_d  = sum;
                rise_d = ~acc_q[MSB] & sum[MSB];
            end
        end

        lo_d   = lo_q;
        freq_d = freq_q;
        ctrl_d = ctrl_q;
        if (wr_en) begin
            case (wr_addr)
                2'd0:    lo_d   = wr_data;
                2'd1:    freq_d = {wr_data[HI_BITS-1:0], lo_q};
                2'd2:    ctrl_d = wr_data[1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            acc_q   <= '0;
            rise_q  <= 1'b0;
            freq_q  <= '0;
            lo_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            acc_q   <= acc_d;
            rise_q  <= rise_d;
            freq_q  <= freq_d;
            lo_q    <= lo_d;
            ctrl_q  <= ctrl_d;
        end
    end

`ifdef HARD_SYNC_EN
    logic sync_pending_q, sync_pending_d;

    // A sync arriving on the consuming edge survives for the next tick.
    always_comb begin
        sync_hit       = ctrl_q[1] & sync_pending_q;
        sync_pending_d = sync_in | (sync_pending_q & ~tick_now);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_pending_q <= 1'b0;
        end else begin
            sync_pending_q <= sync_pending_d;
        end
    end
`else
    logic sync_unused;

    always_comb begin
        sync_hit    = 1'b0;
        sync_unused = sync_in ^ ctrl_q[1];
    end
`endif

    assign accumulator = acc_q;
    assign acc_msb     = acc_q[MSB];
    assign msb_rise    = rise_q;
    assign tick        = tick_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Randomized and directed bench for phase_accumulator against a tick-level arithmetic reference model.
module tb_phase_accumulator;
    localparam int DIV  = 4;
    localparam longint MOD  = 64'd1 << 24;
    localparam longint HALF = 64'd1 << 23;
`ifdef HARD_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        sync_in;
    logic [23:0] accumulator;
    logic        acc_msb;
    logic        msb_rise;
    logic        tick;
    logic [23:0] unused_acc_div1;
    logic        unused_msb_div1;
    logic        unused_rise_div1;
    logic        tick_div1;

    phase_accumulator #(.ACCUMULATOR_BITS(24), .FREQ_BITS(16), .PRESCALE_DIV(DIV)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sync_in(sync_in), .accumulator(accumulator), .acc_msb(acc_msb),
        .msb_rise(msb_rise), .tick(tick)
    );

    phase_accumulator #(.ACCUMULATOR_BITS(24), .FREQ_BITS(16), .PRESCALE_DIV(1)) u_dut_div1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sync_in(sync_in), .accumulator(unused_acc_div1), .acc_msb(unused_msb_div1),
        .msb_rise(unused_rise_div1), .tick(tick_div1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int rise_cnt;

    // Reference model state, kept as plain integers.
    longint m_acc;
    int     m_freq, m_lo, m_ctrl, m_edge, m_ticks;
    bit     m_pend, m_tick, m_rise;

    logic [23:0] ap, a0, a1;
    int          n, t0;
    bit          found;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit we, input bit [1:0] a, input bit [7:0] d, input bit s);
        longint nxt;
        wr_en = we; wr_addr = a; wr_data = d; sync_in = s;
        @(posedge clk);
        m_edge++;
        m_tick = (m_edge % DIV == 0);
        m_rise = 1'b0;
        if (m_tick) begin
            m_ticks++;
            if (m_ctrl % 2 == 1) m_acc = 0;
            else if (SYNC && (m_ctrl / 2) % 2 == 1 && m_pend) m_acc = 0;
            else begin
                nxt    = (m_acc + m_freq) % MOD;
                m_rise = (m_acc < HALF) && (nxt >= HALF);
                m_acc  = nxt;
            end
            m_pend = 1'b0;
        end
        if (s) m_pend = 1'b1;
        if (we) begin
            case (a)
                2'd0:    m_lo = d;
                2'd1:    m_freq = d * 256 + m_lo;
                2'd2:    m_ctrl = d % 4;
                default: ;
            endcase
        end
        @(negedge clk);
        wr_en = 1'b0; sync_in = 1'b0;
        check("acc", accumulator, m_acc[31:0]);
        check("acc_msb", acc_msb, (m_acc >= HALF) ? 1 : 0);
        check("msb_rise", msb_rise, m_rise);
        check("tick", tick, m_tick);
        if (msb_rise) rise_cnt++;
    endtask

    task automatic wr(input bit [1:0] a, input bit [7:0] d);
        step(1'b1, a, d, 1'b0);
    endtask

    task automatic run_to_tick();
        for (int i = 0; i < 3 * DIV; i++) begin
            step(1'b0, 2'd0, 8'd0, 1'b0);
            if (tick) return;
        end
        check("tick_timeout", tick, 1);
    endtask

    // Called at a falling edge; pulses reset between clock edges.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_acc", accumulator, 0);
        check("rst_msb", acc_msb, 0);
        check("rst_rise", msb_rise, 0);
        check("rst_tick", tick, 0);
        #1 reset = 1'b0;
        m_acc = 0; m_freq = 0; m_lo = 0; m_ctrl = 0; m_pend = 1'b0;
        m_edge = 0; m_ticks = 0; m_tick = 1'b0; m_rise = 1'b0;
    endtask

    task automatic first_tick(input string tag);
        n = 0; found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b0, 2'd0, 8'd0, 1'b0);
            n++;
            if (tick) found = 1'b1;
        end
        check(tag, n, DIV);
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; sync_in = 1'b0;
        rise_cnt = 0;
        @(negedge clk);
        do_reset();
        first_tick("first_tick");

        // Half-scale step: MSB rises once at 256 ticks, wraps silently at 512.
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h80);
        t0 = m_ticks; rise_cnt = 0;
        while (m_ticks < t0 + 256) step(1'b0, 2'd0, 8'd0, 1'b0);
        check("acc_half", accumulator, 32'h800000);
        check("rise_half", rise_cnt, 1);
        while (m_ticks < t0 + 512) step(1'b0, 2'd0, 8'd0, 1'b0);
        check("acc_wrap", accumulator, 0);
        check("rise_wrap", rise_cnt, 1);

        // Low byte alone must not change the step.
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h01);
        wr(2'd0, 8'hFF);
        run_to_tick(); a0 = accumulator;
        run_to_tick(); a1 = accumulator;
        check("step_lo_only", a1 - a0, 32'h0100);
        wr(2'd1, 8'h02);
        run_to_tick(); a0 = accumulator;
        run_to_tick(); a1 = accumulator;
        check("step_committed", a1 - a0, 32'h02FF);

        // Test bit clears and holds the phase.
        @(negedge clk);
        do_reset();
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h40);
        t0 = m_ticks;
        while (m_ticks < t0 + 256) step(1'b0, 2'd0, 8'd0, 1'b0);
        check("acc_quarter", accumulator, 32'h400000);
        wr(2'd2, 8'h01);
        run_to_tick();
        check("test_clear", accumulator, 0);
        check("test_no_rise", msb_rise, 0);
        run_to_tick();
        check("test_hold", accumulator, 0);
        wr(2'd2, 8'h00);
        run_to_tick();
        check("test_resume", accumulator, 32'h4000);

        // Hard sync, enabled then disabled.
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h01);
        wr(2'd2, 8'h02);
        run_to_tick(); ap = accumulator;
        step(1'b0, 2'd0, 8'd0, 1'b0);
        step(1'b0, 2'd0, 8'd0, 1'b1);
        run_to_tick();
        check("sync_en", accumulator, SYNC ? 32'h0 : 32'(ap + 24'h0100));
        check("sync_no_rise", msb_rise, 0);
        wr(2'd2, 8'h00);
        run_to_tick(); ap = accumulator;
        step(1'b0, 2'd0, 8'd0, 1'b1);
        run_to_tick();
        check("sync_dis", accumulator, 32'(ap + 24'h0100));

        // Commit landing in the tick-high cycle.
        wr(2'd0, 8'h10);
        wr(2'd1, 8'h00);
        wr(2'd0, 8'h00);
        run_to_tick(); ap = accumulator;
        run_to_tick(); a0 = accumulator;
        step(1'b1, 2'd1, 8'h20, 1'b0);
        run_to_tick(); a1 = accumulator;
        check("collide_old", a0 - ap, 32'h0010);
        check("collide_new", a1 - a0, 32'h2000);

        // Random traffic; test bit set only occasionally so the phase keeps moving.
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bit       we;
            bit [1:0] a;
            bit [7:0] d;
            we = ($urandom_range(0, 3) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom_range(0, 255));
            if (a == 2'd2) d[0] = ($urandom_range(0, 7) == 0);
            step(we, a, d, $urandom_range(0, 9) == 0);
            check("div1_tick", tick_div1, 1);
        end

        // Asynchronous reset mid-count with a live phase.
        wr(2'd2, 8'h00);
        wr(2'd0, 8'h56);
        wr(2'd1, 8'h34);
        step(1'b0, 2'd0, 8'd0, 1'b0);
        do_reset();
        first_tick("first_tick_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
